// File: rtl/alu_mp_seq_if.sv
// Requester-side bundle of alu_mp_seq: start/abort request, operation and
// length, busy/done/err status and the final flag register.
//   master : requester (drives start/op/len/abort, observes status/flags)
//   slave  : alu_mp_seq
interface alu_mp_seq_if #(
  parameter int op_wl   = 8,
  parameter int addr_wl = 4
) ();
  logic               start_in;
  logic [op_wl-1:0]   op_in;
  logic [addr_wl:0]   len_in;
  logic               abort_in;
  logic               busy_out;
  logic               done_out;
  logic               err_out;
  logic               z_out;
  logic               s_out;
  logic               c_out;
  logic               ovr_out;

  modport master (
    output start_in, op_in, len_in, abort_in,
    input  busy_out, done_out, err_out, z_out, s_out, c_out, ovr_out
  );

  modport slave (
    input  start_in, op_in, len_in, abort_in,
    output busy_out, done_out, err_out, z_out, s_out, c_out, ovr_out
  );
endinterface

// File: rtl/alu_mp_seq.sv
// Multi-precision sequencer for alu_arith. Runs one ADD/SUB/INC/DEC/MOV over
// len data_wl-bit words, LS word first, one word per cycle, chaining the ALU
// flags between words through the flag register.
// Ports:
//   clk_in, rst_in     clock, asynchronous active-high reset
//   req                requester bundle (start/op/len/abort, busy/done/err,
//                      final z/s/c/ovr)
//   opd_addr_out       word index to operand RAMs; opa/opb_data_in read back
//   res_*_out          result RAM write port
//   alu_*_out/_in      operands, opcode and flags to/from one alu_arith
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; illegal requests answered with err pulse
// RUN   | one word per cycle, idx 0..len-1, result written each cycle
// DONE  | one-cycle done pulse, flags hold the final result flags
module alu_mp_seq #(
  parameter int data_wl = 16,
  parameter int op_wl   = 8,
  parameter int addr_wl = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  alu_mp_seq_if.slave        req,
  output logic [addr_wl-1:0] opd_addr_out,
  input  logic [data_wl-1:0] opa_data_in,
  input  logic [data_wl-1:0] opb_data_in,
  output logic               res_we_out,
  output logic [addr_wl-1:0] res_addr_out,
  output logic [data_wl-1:0] res_data_out,
  output logic [data_wl-1:0] alu_a_out,
  output logic [data_wl-1:0] alu_b_out,
  output logic [op_wl-1:0]   alu_op_out,
  output logic               alu_z_out,
  output logic               alu_s_out,
  output logic               alu_c_out,
  output logic               alu_ovr_out,
  input  logic [data_wl-1:0] alu_res_in,
  input  logic               alu_z_in,
  input  logic               alu_s_in,
  input  logic               alu_c_in,
  input  logic               alu_ovr_in
);
  localparam int LEN_W = addr_wl + 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2**addr_wl);
  localparam logic [op_wl-1:0] OP_CONT = op_wl'(8'h20);
  localparam logic [op_wl-1:0] OP_NOP  = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [op_wl-1:0]   op_q, op_d;
  logic [3:0]         flags_q, flags_d;  // {z, s, c, ovr}
  logic               err_q, err_d;

  function automatic logic op_legal(input logic [op_wl-1:0] op);
    return (op == op_wl'(8'h00)) || (op == op_wl'(8'h01)) || (op == op_wl'(8'h04)) ||
           (op == op_wl'(8'h08)) || (op == op_wl'(8'h0B));
  endfunction

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      op_q    <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      op_q    <= op_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    len_d      = len_q;
    op_d       = op_q;
    flags_d    = flags_q;
    err_d      = 1'b0;
    res_we_out = 1'b0;
    alu_op_out = OP_NOP;
    case (state_q)
      S_IDLE: begin
        if (req.start_in) begin
          if (op_legal(req.op_in) && (req.len_in != '0) && (req.len_in <= MAX_LEN)) begin
            op_d    = req.op_in;
            len_d   = req.len_in;
            idx_d   = '0;
            state_d = S_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        // word 0 starts the chain; later words consume the previous flags
        alu_op_out = (idx_q == '0) ? op_q : (op_q | OP_CONT);
        if (req.abort_in) begin
          state_d = S_IDLE;
        end else begin
          res_we_out = 1'b1;
          flags_d    = {alu_z_in, alu_s_in, alu_c_in, alu_ovr_in};
          idx_d      = idx_q + LEN_W'(1);
          if (idx_q == (len_q - LEN_W'(1))) state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // idx has one spare bit so len = 2**addr_wl terminates without wrapping
  assign opd_addr_out = idx_q[addr_wl-1:0];
  assign res_addr_out = idx_q[addr_wl-1:0];
  assign res_data_out = alu_res_in;
  assign alu_a_out    = opa_data_in;
  assign alu_b_out    = opb_data_in;
  assign {alu_z_out, alu_s_out, alu_c_out, alu_ovr_out} = flags_q;

  assign req.busy_out = (state_q != S_IDLE);
  assign req.done_out = (state_q == S_DONE);
  assign req.err_out  = err_q;
  assign {req.z_out, req.s_out, req.c_out, req.ovr_out} = flags_q;
endmodule

// File: tb/tb_alu_mp_seq.sv
module tb_alu_mp_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  opd_addr, res_addr;
  logic [15:0] opa_data, opb_data, res_data, alu_a, alu_b, alu_res;
  logic        res_we;
  logic [7:0]  alu_op;
  logic        alu_z_o, alu_s_o, alu_c_o, alu_ovr_o;
  logic        alu_z_i, alu_s_i, alu_c_i, alu_ovr_i;

  alu_mp_seq_if #(.op_wl(8), .addr_wl(4)) bus ();

  alu_mp_seq #(.data_wl(16), .op_wl(8), .addr_wl(4)) dut (
    .clk_in(clk), .rst_in(rst), .req(bus),
    .opd_addr_out(opd_addr), .opa_data_in(opa_data), .opb_data_in(opb_data),
    .res_we_out(res_we), .res_addr_out(res_addr), .res_data_out(res_data),
    .alu_a_out(alu_a), .alu_b_out(alu_b), .alu_op_out(alu_op),
    .alu_z_out(alu_z_o), .alu_s_out(alu_s_o), .alu_c_out(alu_c_o), .alu_ovr_out(alu_ovr_o),
    .alu_res_in(alu_res),
    .alu_z_in(alu_z_i), .alu_s_in(alu_s_i), .alu_c_in(alu_c_i), .alu_ovr_in(alu_ovr_i)
  );

  always #5 clk = ~clk;

  // operand RAMs (combinational read) and expected result words
  logic [15:0] ma [16];
  logic [15:0] mb [16];
  logic [15:0] er [16];
  assign opa_data = ma[opd_addr];
  assign opb_data = mb[opd_addr];

  // reference alu_arith: unary ops work on B, bit 5 selects the chained form
  logic [15:0] x, y;
  logic        ci, arith, cont;
  logic [16:0] sum;
  always_comb begin
    cont = alu_op[5];
    x = alu_b; y = 16'h0; ci = 1'b0; arith = 1'b1; sum = 17'h0;
    alu_res = 16'h0;
    {alu_z_i, alu_s_i, alu_c_i, alu_ovr_i} = 4'b0;
    case (alu_op & 8'hDF)
      8'h01: begin x = alu_b; y = 16'h0000; ci = cont ? alu_c_o : 1'b1; end
      8'h04: begin x = alu_b; y = 16'hFFFF; ci = cont ? alu_c_o : 1'b0; end
      8'h08: begin x = alu_a; y = alu_b;    ci = cont ? alu_c_o : 1'b0; end
      8'h0B: begin x = alu_a; y = ~alu_b;   ci = cont ? alu_c_o : 1'b1; end
      default: arith = 1'b0;
    endcase
    if (arith) begin
      sum = {1'b0, x} + {1'b0, y} + {16'h0, ci};
      alu_res   = sum[15:0];
      alu_c_i   = sum[16];
      alu_s_i   = sum[15];
      alu_z_i   = (sum[15:0] == 16'h0) && (!cont || alu_z_o);
      alu_ovr_i = (x[15] == y[15]) && (sum[15] != x[15]);
    end else if ((alu_op & 8'hDF) == 8'h00) begin
      alu_res = alu_b;
      {alu_z_i, alu_s_i, alu_c_i, alu_ovr_i} = {alu_z_o, alu_s_o, alu_c_o, alu_ovr_o};
    end
  end

  // words in the 64-bit fields are written MS word first
  typedef struct packed {
    logic [7:0]       op;
    logic [4:0]       len;
    logic [3:0][15:0] a;
    logic [3:0][15:0] b;
    logic [3:0][15:0] r;
    logic             err;
    logic [3:0]       fl;   // {z, s, c, ovr}
  } vec_t;

  typedef struct packed {
    logic [3:0]  addr;
    logic [15:0] data;
    logic [7:0]  op;
  } wr_t;

  vec_t tv [11];
  wr_t  exp_q [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic monitor_loop();
    wr_t w;
    forever begin
      @(negedge clk);
      if (res_we) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_write: got addr %0h data %0h op %0h expected no write", res_addr, res_data, alu_op);
        end else begin
          w = exp_q.pop_front();
          chk("wr_addr", res_addr, w.addr);
          chk("wr_data", res_data, w.data);
          chk("wr_op", alu_op, w.op);
          chk("addr_match", res_addr, opd_addr);
        end
      end
    end
  endtask

  function automatic logic [3:0] flags();
    return {bus.z_out, bus.s_out, bus.c_out, bus.ovr_out};
  endfunction

  task automatic load_vec(input vec_t v);
    for (int j = 0; j < 16; j++) begin ma[j] = 16'h0; mb[j] = 16'h0; er[j] = 16'h0; end
    for (int j = 0; j < 4; j++) begin ma[j] = v.a[j]; mb[j] = v.b[j]; er[j] = v.r[j]; end
  endtask

  task automatic do_run(input logic [7:0] op, input logic [4:0] len, input logic err,
                        input logic [3:0] fl);
    int  k;
    wr_t w;
    if (!err)
      for (int i = 0; i < int'(len); i++) begin
        w.addr = 4'(i); w.data = er[i]; w.op = (i == 0) ? op : (op | 8'h20);
        exp_q.push_back(w);
      end
    @(posedge clk); #1;
    bus.start_in = 1'b1; bus.op_in = op; bus.len_in = len;
    @(posedge clk); #1;
    bus.start_in = 1'b0;
    @(negedge clk);
    if (err) begin
      chk("err_pulse", bus.err_out, 1);
      chk("err_busy", bus.busy_out, 0);
      @(negedge clk);
      chk("err_one_cycle", bus.err_out, 0);
    end else begin
      chk("run_busy", bus.busy_out, 1);
      chk("run_no_err", bus.err_out, 0);
      k = 1;
      while (!bus.done_out && k < int'(len) + 6) begin
        @(negedge clk);
        k++;
      end
      chk("done_cycle", k, int'(len) + 1);
      chk("done_busy", bus.busy_out, 1);
      @(negedge clk);
      chk("done_one_cycle", bus.done_out, 0);
      chk("idle_after_done", bus.busy_out, 0);
      chk("idle_op", alu_op, 8'hFF);
    end
    chk("flags", flags(), fl);
    chk("writes_drained", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_t w;
    bus.start_in = 1'b0; bus.op_in = 8'h0; bus.len_in = 5'd0; bus.abort_in = 1'b0;
    for (int j = 0; j < 16; j++) begin ma[j] = 16'h0; mb[j] = 16'h0; er[j] = 16'h0; end

    tv[0]  = '{8'h08, 5'd2,  64'h0000_0000_0001_FFFF, 64'h0000_0000_0002_0001, 64'h0000_0000_0004_0000, 1'b0, 4'b0000};
    tv[1]  = '{8'h0B, 5'd3,  64'h0,                   64'h0000_0000_0000_0001, 64'h0000_FFFF_FFFF_FFFF, 1'b0, 4'b0100};
    tv[2]  = '{8'h01, 5'd2,  64'h0,                   64'h0000_0000_FFFF_FFFF, 64'h0,                   1'b0, 4'b1010};
    tv[3]  = '{8'h00, 5'd2,  64'h0,                   64'h0000_0000_8000_1234, 64'h0000_0000_8000_1234, 1'b0, 4'b1010};
    tv[4]  = '{8'h04, 5'd2,  64'h0,                   64'h0000_0000_0001_0000, 64'h0000_0000_0000_FFFF, 1'b0, 4'b0010};
    tv[5]  = '{8'h08, 5'd1,  64'h0000_0000_0000_7FFF, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_8000, 1'b0, 4'b0101};
    tv[6]  = '{8'h03, 5'd2,  64'h0, 64'h0, 64'h0, 1'b1, 4'b0101};
    tv[7]  = '{8'h08, 5'd0,  64'h0, 64'h0, 64'h0, 1'b1, 4'b0101};
    tv[8]  = '{8'h08, 5'd17, 64'h0, 64'h0, 64'h0, 1'b1, 4'b0101};
    tv[9]  = '{8'h0C, 5'd1,  64'h0, 64'h0, 64'h0, 1'b1, 4'b0101};
    tv[10] = '{8'h0B, 5'd2,  64'h0000_0000_0003_0005, 64'h0000_0000_0003_0005, 64'h0,                   1'b0, 4'b1010};

    fork monitor_loop(); join_none

    #12;
    chk("rst_busy", bus.busy_out, 0);
    chk("rst_done", bus.done_out, 0);
    chk("rst_err", bus.err_out, 0);
    chk("rst_we", res_we, 0);
    chk("rst_op", alu_op, 8'hFF);
    chk("rst_flags", flags(), 4'b0000);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      load_vec(tv[i]);
      do_run(tv[i].op, tv[i].len, tv[i].err, tv[i].fl);
    end

    // abort in the second RUN cycle; a start during RUN must be ignored
    for (int j = 0; j < 4; j++) begin ma[j] = 16'(j + 1); mb[j] = 16'((j + 1) * 16); end
    w.addr = 4'h0; w.data = 16'h0011; w.op = 8'h08;
    exp_q.push_back(w);
    @(posedge clk); #1;
    bus.start_in = 1'b1; bus.op_in = 8'h08; bus.len_in = 5'd4;
    @(posedge clk); #1;
    bus.op_in = 8'h01;
    @(negedge clk);
    chk("abort_busy", bus.busy_out, 1);
    @(posedge clk); #1;
    bus.start_in = 1'b0; bus.abort_in = 1'b1;
    @(negedge clk);
    chk("abort_no_we", res_we, 0);
    chk("busy_start_no_err", bus.err_out, 0);
    @(posedge clk); #1 bus.abort_in = 1'b0;
    @(negedge clk);
    chk("abort_idle", bus.busy_out, 0);
    chk("abort_no_done", bus.done_out, 0);
    repeat (3) @(negedge clk);
    chk("abort_still_idle", bus.busy_out, 0);
    chk("abort_flags", flags(), 4'b0000);
    chk("abort_drained", exp_q.size(), 0);

    // asynchronous reset in the middle of a run
    for (int j = 0; j < 4; j++) begin ma[j] = 16'hFFFF; mb[j] = 16'h0001; end
    w.addr = 4'h0; w.data = 16'h0000; w.op = 8'h08;
    exp_q.push_back(w);
    @(posedge clk); #1;
    bus.start_in = 1'b1; bus.op_in = 8'h08; bus.len_in = 5'd4;
    @(posedge clk); #1 bus.start_in = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_flags", flags(), 4'b1010);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", bus.busy_out, 0);
    chk("midrst_we", res_we, 0);
    chk("midrst_done", bus.done_out, 0);
    chk("midrst_flags", flags(), 4'b0000);
    chk("midrst_op", alu_op, 8'hFF);
    @(posedge clk); #1 rst = 1'b0;
    chk("midrst_drained", exp_q.size(), 0);
    load_vec(tv[0]);
    do_run(tv[0].op, tv[0].len, tv[0].err, tv[0].fl);

    // full length: carry ripples through all 16 words
    for (int j = 0; j < 16; j++) begin ma[j] = 16'hFFFF; mb[j] = 16'h0; er[j] = 16'h0; end
    mb[0] = 16'h0001;
    do_run(8'h08, 5'd16, 1'b0, 4'b1010);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
